// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage pipelined bitwise/rotate unit with valid/ready handshake and accumulator
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             parity,
    output logic             err
);

    logic             ready_q, ready_d;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [3:0]       s1_sel_q, s1_sel_d;
    logic             s1_acc_en_q, s1_acc_en_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic               advance2;
    logic               accept;
    logic               s2_load;
    logic [WIDTH-1:0]   op_a;
    logic [SHW:0]       amt;
    logic [2*WIDTH-1:0] rotl_x;
    logic [2*WIDTH-1:0] rotr_x;
    logic [WIDTH-1:0]   res;
    logic               illegal;

    // S2 result; the amount is folded into [0, WIDTH) so the doubled-operand shift is a true rotate
    always_comb begin
        op_a = s1_acc_en_q ? acc_q : s1_a_q;
        amt  = {1'b0, s1_b_q[SHW-1:0]};
        if (amt >= (SHW+1)'(WIDTH)) begin
            amt = amt - (SHW+1)'(WIDTH);
        end
        rotl_x  = {op_a, op_a} << amt;
        rotr_x  = {op_a, op_a} >> amt;
        res     = '0;
        illegal = 1'b0;
        case (s1_sel_q)
            4'd8:    res = op_a & s1_b_q;
            4'd9:    res = op_a | s1_b_q;
            4'd10:   res = op_a ^ s1_b_q;
            4'd11:   res = ~(op_a & s1_b_q);
            4'd12:   res = ~(op_a | s1_b_q);
            4'd13:   res = ~(op_a ^ s1_b_q);
            4'd14:   res = rotl_x[2*WIDTH-1:WIDTH];
            4'd15:   res = rotr_x[WIDTH-1:0];
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        advance2 = !out_valid_q || out_ready;
        in_ready = ready_q && (!s1_valid_q || advance2);
        accept   = in_valid && in_ready;
        s2_load  = advance2 && s1_valid_q;

        ready_d     = 1'b1;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_sel_d    = s1_sel_q;
        s1_acc_en_d = s1_acc_en_q;
        out_valid_d = out_valid_q;
        c_d         = c_q;
        zero_d      = zero_q;
        parity_d    = parity_q;
        err_d       = err_q;
        acc_d       = acc_q;

        if (accept) begin
            s1_valid_d  = 1'b1;
            s1_a_d      = a;
            s1_b_d      = b;
            s1_sel_d    = sel;
            s1_acc_en_d = acc_en;
        end else if (advance2) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            out_valid_d = 1'b1;
            c_d         = res;
            zero_d      = (res == '0);
            parity_d    = ^res;
            err_d       = illegal;
            acc_d       = res;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_sel_q    <= '0;
            s1_acc_en_q <= 1'b0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            zero_q      <= 1'b0;
            parity_q    <= 1'b0;
            err_q       <= 1'b0;
            acc_q       <= '0;
        end else begin
            ready_q     <= ready_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_sel_q    <= s1_sel_d;
            s1_acc_en_q <= s1_acc_en_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            zero_q      <= zero_d;
            parity_q    <= parity_d;
            err_q       <= err_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign err       = err_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - randomized and directed bench for logic_unit_pipe against a beat-level model
module tb_logic_unit_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, acc_en, acc_clr;
    logic [7:0] a, b, c;
    logic [3:0] sel;
    logic       out_valid, out_ready, zero, parity, err;

    logic        v12, rdy12, oval12, z12, p12, e12;
    logic [11:0] a12, b12, c12;
    logic [3:0]  sel12;

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .c(c), .zero(zero),
        .parity(parity), .err(err)
    );

    logic_unit_pipe #(.WIDTH(12)) u12 (
        .clk(clk), .rst_n(rst_n), .in_valid(v12), .in_ready(rdy12),
        .a(a12), .b(b12), .sel(sel12), .acc_en(1'b0), .acc_clr(1'b0),
        .out_valid(oval12), .out_ready(1'b1), .c(c12), .zero(z12),
        .parity(p12), .err(e12)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [8:0]  exp_q[$];
    logic [9:0]  out_log[$];
    int          out_cyc[$];
    int          acc_cyc[$];
    logic [7:0]  model_acc = '0;
    logic        stall_prev = 1'b0;
    logic [9:0]  prev_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Reference: {err, c} of one beat from the opcode table
    function automatic logic [8:0] ref8(input logic [7:0] aa, input logic [7:0] bb, input logic [3:0] s);
        logic [7:0] r;
        int n;
        n = int'(bb[2:0]) % 8;
        r = aa;
        case (s)
            4'd8:  return {1'b0, aa & bb};
            4'd9:  return {1'b0, aa | bb};
            4'd10: return {1'b0, aa ^ bb};
            4'd11: return {1'b0, ~(aa & bb)};
            4'd12: return {1'b0, ~(aa | bb)};
            4'd13: return {1'b0, ~(aa ^ bb)};
            4'd14: begin
                for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
                return {1'b0, r};
            end
            4'd15: begin
                for (int i = 0; i < n; i++) r = {r[0], r[7:1]};
                return {1'b0, r};
            end
            default: return 9'h100;
        endcase
    endfunction

    task automatic step();
        logic [8:0] e;
        logic [7:0] aa;
        #1;
        if (stall_prev) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_out", {err, zero, c}, prev_out);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("c", c, e[7:0]);
                chk("err", err, e[8]);
                chk("zero", zero, e[7:0] == 8'h00);
                chk("parity", parity, ^e[7:0]);
            end
            out_log.push_back({err, zero, c});
            out_cyc.push_back(cyc);
        end
        if (in_valid && in_ready) begin
            aa = acc_en ? model_acc : a;
            e = ref8(aa, b, sel);
            model_acc = e[7:0];
            exp_q.push_back(e);
            acc_cyc.push_back(cyc);
        end
        if (acc_clr) model_acc = '0;
        stall_prev = out_valid && !out_ready;
        prev_out = {err, zero, c};
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        step();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic clear_logs();
        out_log.delete();
        out_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic beat(input logic [3:0] s, input logic [7:0] aa, input logic [7:0] bb, input logic ae);
        in_valid = 1'b1;
        sel = s;
        a = aa;
        b = bb;
        acc_en = ae;
        step();
    endtask

    task automatic run12(input string tag, input logic [3:0] s, input logic [11:0] aa,
                         input logic [11:0] bb, input logic [11:0] expc, input logic expp);
        int k;
        chk({tag, "_ready"}, rdy12, 1);
        v12 = 1'b1;
        sel12 = s;
        a12 = aa;
        b12 = bb;
        @(posedge clk);
        @(negedge clk);
        v12 = 1'b0;
        k = 0;
        #1;
        while (!oval12 && k < 5) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_valid"}, oval12, 1);
        chk({tag, "_c"}, c12, expc);
        chk({tag, "_parity"}, p12, expp);
        chk({tag, "_err"}, e12, 0);
        @(negedge clk);
    endtask

    logic [7:0] exp_stream [8];

    initial begin
        exp_stream = '{8'h02, 8'h03, 8'h01, 8'hFD, 8'hFC, 8'hFE, 8'h10, 8'h40};
        rst_n = 1'b0;
        in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sel = '0;
        v12 = 1'b0; a12 = '0; b12 = '0; sel12 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outs", {c, zero, parity, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // opcodes 8..15 back to back
        clear_logs();
        for (int s = 8; s < 16; s++) beat(4'(s), 8'h02, 8'h03, 1'b0);
        drain();
        chk("stream_count", out_log.size(), 8);
        if (out_log.size() == 8) begin
            for (int i = 0; i < 8; i++) chk($sformatf("stream_c%0d", i), out_log[i][7:0], exp_stream[i]);
            chk("stream_latency", out_cyc[0] - acc_cyc[0], 2);
            chk("stream_rate", out_cyc[7] - out_cyc[0], 7);
        end

        // illegal opcode then a legal one
        clear_logs();
        beat(4'd3, 8'hFF, 8'hFF, 1'b0);
        beat(4'd9, 8'h10, 8'h01, 1'b0);
        drain();
        chk("illegal_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            chk("illegal_out", out_log[0], 10'h300);
            chk("legal_err", out_log[1][9], 0);
        end

        // stall: only two beats fit while the output is blocked
        clear_logs();
        out_ready = 1'b0;
        in_valid = 1'b1; sel = 4'd10; a = 8'h5A; b = 8'h0F; acc_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (acc_cyc.size() > i) begin a = a + 8'h11; sel = 4'd13; end
        end
        chk("stall_accepts", acc_cyc.size(), 2);
        chk("stall_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && acc_cyc.size() < 3; i++) step();
        drain();
        chk("stall_results", out_log.size(), 3);

        // accumulator chain at full rate
        clear_logs();
        in_valid = 1'b0; acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        beat(4'd9, 8'h01, 8'h00, 1'b0);
        beat(4'd14, 8'($urandom), 8'h01, 1'b1);
        beat(4'd14, 8'($urandom), 8'h01, 1'b1);
        drain();
        chk("chain_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("chain_c0", out_log[0][7:0], 8'h01);
            chk("chain_c1", out_log[1][7:0], 8'h02);
            chk("chain_c2", out_log[2][7:0], 8'h04);
            chk("chain_rate", out_cyc[2] - out_cyc[0], 2);
        end

        // reset with two beats in flight
        out_ready = 1'b0;
        beat(4'd9, 8'hA5, 8'h00, 1'b0);
        beat(4'd9, 8'h3C, 8'h00, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_c", c, 0);
        exp_q.delete();
        model_acc = '0;
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        clear_logs();
        repeat (5) step();
        chk("post_rst_no_out", out_log.size(), 0);
        chk("post_rst_in_ready", in_ready, 1);
        beat(4'd9, 8'hFF, 8'h00, 1'b1);
        drain();
        chk("post_rst_acc", out_log.size() == 1 ? out_log[0][7:0] : 8'hEE, 8'h00);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = 8'($urandom);
            b = 8'($urandom);
            sel = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
            acc_en = $urandom_range(0, 1) == 1;
            step();
        end
        drain();

        // non-power-of-two width rotate folding
        run12("w12_rotr", 4'd15, 12'h001, 12'd13, 12'h800, 1'b1);
        run12("w12_rotl", 4'd14, 12'h001, 12'd15, 12'h008, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
